// File: rtl/timer_multicanal.sv
// N-channel programmable timer (one-shot / retriggerable / periodic); sinal is high D*TICK_DIV clocks after a start.
// All outputs registered, 1-clk response to start/stop; no backpressure, every trigger is evaluated every clock.
module timer_multicanal #(
  parameter int N_CANAIS = 4,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CANAIS-1:0]       start,
  input  logic [N_CANAIS-1:0]       stop,
  input  logic [2*N_CANAIS-1:0]     modo,
  input  logic [DUR_W*N_CANAIS-1:0] duracao,
  output logic [N_CANAIS-1:0]       sinal,
  output logic [N_CANAIS-1:0]       fim,
  output logic                      ocupado
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [1:0]       M_RETRIG = 2'b01;
  localparam logic [1:0]       M_PERIOD = 2'b10;

  typedef enum logic {IDLE, ATIVO} state_t;

  logic [N_CANAIS-1:0] sinal_nx;

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [1:0]       mode_q, mode_d;
    logic             sinal_q, fim_q, fim_d;
    logic [DUR_W-1:0] dur_in;
    logic [1:0]       mode_in;
    logic             tick, expira, aceita;

    assign dur_in  = duracao[DUR_W*i +: DUR_W];
    assign mode_in = modo[2*i +: 2];
    assign tick    = (pre_q == PRE_MAX);
    // cnt never reaches D, so comparing against D-1 cannot wrap
    assign expira  = (state_q == ATIVO) && tick && (cnt_q == dur_q - DUR_ONE);
    assign aceita  = start[i] && (dur_in != '0);

    always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      dur_d   = dur_q;
      mode_d  = mode_q;
      fim_d   = 1'b0;
      if (stop[i]) begin
        state_d = IDLE;
        pre_d   = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (aceita) begin
              state_d = ATIVO;
              mode_d  = mode_in;
              dur_d   = dur_in;
              pre_d   = '0;
              cnt_d   = '0;
            end
          end
          ATIVO: begin
            // expiry beats a coincident start; start is seen again next clock
            if (expira) begin
              fim_d = 1'b1;
              pre_d = '0;
              cnt_d = '0;
              if (mode_q != M_PERIOD) state_d = IDLE;
            end else if ((mode_q == M_RETRIG) && aceita) begin
              mode_d = mode_in;
              dur_d  = dur_in;
              pre_d  = '0;
              cnt_d  = '0;
            end else if (tick) begin
              pre_d = '0;
              cnt_d = cnt_q + DUR_ONE;
            end else begin
              pre_d = pre_q + PRE_ONE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        pre_q   <= '0;
        cnt_q   <= '0;
        dur_q   <= '0;
        mode_q  <= '0;
        sinal_q <= 1'b0;
        fim_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        pre_q   <= pre_d;
        cnt_q   <= cnt_d;
        dur_q   <= dur_d;
        mode_q  <= mode_d;
        sinal_q <= (state_d == ATIVO);
        fim_q   <= fim_d;
      end
    end

    assign sinal_nx[i] = (state_d == ATIVO);
    assign sinal[i]    = sinal_q;
    assign fim[i]      = fim_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ocupado <= 1'b0;
    else        ocupado <= |sinal_nx;
  end

endmodule
